// File: rtl/nios_core_mem_checker_pkg.sv
// rtl/nios_core_mem_checker_pkg.sv - shared types, widths and LFSR helper for the memory checker
package nios_core_mem_checker_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 11;

    localparam logic [DATA_W-1:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [DATA_W-1:0] DEFAULT_SEED = 32'hA5A5_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Galois step: shift right, fold the polynomial back in when a one falls out.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/nios_core_mem_checker_if.sv
// rtl/nios_core_mem_checker_if.sv - Avalon-MM master bus between the checker and the memory
interface nios_core_mem_checker_if;
    import nios_core_mem_checker_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, chipselect, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write, byteenable, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/nios_core_lfsr32.sv
// rtl/nios_core_lfsr32.sv - 32-bit Galois LFSR pattern source with load and step
module nios_core_lfsr32
    import nios_core_mem_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    output logic [DATA_W-1:0] o_value
);

    logic [DATA_W-1:0] r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= SEED;
        end else if (i_step) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/nios_core_mem_checker.sv
// rtl/nios_core_mem_checker.sv - write an LFSR pattern to memory, read it back and count mismatches
module nios_core_mem_checker
    import nios_core_mem_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED  = DEFAULT_SEED,
    parameter int                DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [CNT_W-1:0]         err_count,
    output logic [ADDR_W-1:0]        first_err_addr,
    nios_core_mem_checker_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_address;
    logic               r_cs;
    logic               r_write;
    logic [CNT_W-1:0]   r_err_count;
    logic [ADDR_W-1:0]  r_first_err_addr;
    logic               r_exp_valid;
    logic [DATA_W-1:0]  r_exp_data;
    logic [ADDR_W-1:0]  r_exp_addr;
    logic               r_cmp_err;
    logic [ADDR_W-1:0]  r_cmp_addr;

    logic               w_accept;
    logic               w_last;
    logic               w_start_test;
    logic               w_lfsr_load;
    logic               w_lfsr_step;
    logic [DATA_W-1:0]  w_lfsr_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = r_cs && !bus.waitrequest;
        w_last       = (r_address == LAST_ADDR);
        w_start_test = 1'b0;
        w_lfsr_load  = 1'b0;
        w_lfsr_step  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_WRITE;
                    w_start_test = 1'b1;
                    w_lfsr_load  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_READ;
                    w_lfsr_load  = 1'b1;
                end else if (w_accept) begin
                    w_lfsr_step  = 1'b1;
                end
            end
            ST_READ: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_DRAIN;
                end else if (w_accept) begin
                    w_lfsr_step  = 1'b1;
                end
            end
            // Hold until the last read's compare result has reached err_count.
            ST_DRAIN: begin
                if (!r_exp_valid) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address        <= '0;
            r_cs             <= 1'b0;
            r_write          <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_exp_valid      <= 1'b0;
            r_exp_data       <= '0;
            r_exp_addr       <= '0;
            r_cmp_err        <= 1'b0;
            r_cmp_addr       <= '0;
        end else begin
            // Read data arrives one cycle after acceptance; compare then, count one cycle later.
            r_exp_valid <= 1'b0;
            r_cmp_err   <= r_exp_valid && (bus.readdata != r_exp_data);
            r_cmp_addr  <= r_exp_addr;
            if (w_start_test) begin
                r_cs             <= 1'b1;
                r_write          <= 1'b1;
                r_address        <= '0;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
            end else begin
                if (r_cmp_err) begin
                    r_err_count <= r_err_count + 1'b1;
                    if (r_err_count == '0) begin
                        r_first_err_addr <= r_cmp_addr;
                    end
                end
                if (w_accept) begin
                    if (r_state == ST_READ) begin
                        r_exp_valid <= 1'b1;
                        r_exp_data  <= w_lfsr_value;
                        r_exp_addr  <= r_address;
                    end
                    if (w_last) begin
                        r_address <= '0;
                        r_write   <= 1'b0;
                        if (r_state == ST_READ) begin
                            r_cs <= 1'b0;
                        end
                    end else begin
                        r_address <= r_address + 1'b1;
                    end
                end
            end
        end
    end

    nios_core_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_lfsr_load),
        .i_step  (w_lfsr_step),
        .o_value (w_lfsr_value)
    );

    assign bus.address    = r_address;
    assign bus.chipselect = r_cs;
    assign bus.write      = r_write;
    assign bus.byteenable = 4'hF;
    assign bus.writedata  = w_lfsr_value;

    assign busy           = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err_count == '0);
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

endmodule
